// File: rtl/tx_serial_cfg_pkg.sv
// Shared definitions for the configurable serial transmitter:
// state/debug encodings, parity modes and frame length.
package tx_serial_cfg_pkg;

  // state values double as their debug codes
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_LOAD = 4'b0001,
    ST_SEND = 4'b0011,
    ST_DONE = 4'b1111
  } state_t;

  localparam logic [3:0] DB_INVALID = 4'b1110;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/tx_serial_cfg_if.sv
// Host-side bus of the serial transmitter: request/data in, line and status out.
interface tx_serial_cfg_if #(parameter int DATA_BITS = 8);
  logic                 partida;
  logic [DATA_BITS-1:0] dados;
  logic                 saida_serial;
  logic                 ocupado;
  logic                 pronto;
  logic                 erro_overrun;
  logic [3:0]           db_estado;

  modport master (
    output partida, dados,
    input  saida_serial, ocupado, pronto, erro_overrun, db_estado
  );

  modport slave (
    input  partida, dados,
    output saida_serial, ocupado, pronto, erro_overrun, db_estado
  );
endinterface

// File: rtl/tx_serial_cfg_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// count so the transmitter advances one bit per period.
module tx_serial_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = conta && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)               count <= '0;
    else if (zera || tick)   count <= '0;
    else if (conta)          count <= count + CW'(1);
  end
endmodule

// File: rtl/tx_serial_cfg.sv
// Configurable asynchronous serial transmitter with a one-word holding buffer.
// state | meaning: IDLE wait for word, LOAD build frame, SEND shift bits, DONE frame finished
module tx_serial_cfg
  import tx_serial_cfg_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 434
) (
  input logic             clock,
  input logic             reset,
  tx_serial_cfg_if.slave  bus
);
  localparam int N  = frame_len(DATA_BITS, PARITY, STOP_BITS);
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_t               state, state_next;
  logic [DATA_BITS-1:0] buf_dados;
  logic                 cheio;
  logic [N-1:0]         shreg, frame;
  logic [BW-1:0]        bit_cnt;
  logic                 erro_q;
  logic                 tick, em_load, em_send, captura;

  assign em_load = (state == ST_LOAD);
  assign em_send = (state == ST_SEND);
  // LOAD frees the buffer this cycle, so a request then is accepted, not dropped
  assign captura = bus.partida && (!cheio || em_load);

  tx_serial_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clock (clock),
    .reset (reset),
    .zera  (em_load),
    .conta (em_send),
    .tick  (tick)
  );

  always_comb begin
    frame = '1;
    frame[0] = 1'b0;
    frame[DATA_BITS:1] = buf_dados;
    if (PARITY == PARITY_ODD)       frame[DATA_BITS+1] = ~^buf_dados;
    else if (PARITY == PARITY_EVEN) frame[DATA_BITS+1] = ^buf_dados;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = cheio ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: state_next = (tick && (bit_cnt == LAST_BIT)) ? ST_DONE : ST_SEND;
      ST_DONE: state_next = cheio ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_dados <= '0;
      cheio     <= 1'b0;
      shreg     <= '1;
      bit_cnt   <= '0;
      erro_q    <= 1'b0;
    end else begin
      erro_q <= bus.partida && cheio && !em_load;
      if (captura) begin
        buf_dados <= bus.dados;
        cheio     <= 1'b1;
      end else if (em_load) begin
        cheio <= 1'b0;
      end
      if (em_load) begin
        shreg   <= frame;
        bit_cnt <= '0;
      end else if (tick) begin
        shreg   <= {1'b1, shreg[N-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    bus.db_estado = DB_INVALID;
    case (state)
      ST_IDLE, ST_LOAD, ST_SEND, ST_DONE: bus.db_estado = state;
      default:                            bus.db_estado = DB_INVALID;
    endcase
  end

  assign bus.saida_serial = em_send ? shreg[0] : 1'b1;
  assign bus.ocupado      = (state != ST_IDLE) || cheio;
  assign bus.pronto       = (state == ST_DONE);
  assign bus.erro_overrun = erro_q;
endmodule

// File: tb/tb_tx_serial_cfg.sv
// Bench for tx_serial_cfg: four format variants, a timeline model checked every
// cycle, plus literal frame/timing expectations.
module tb_tx_serial_cfg;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       partida = 1'b0;
  logic [8:0] dados = '0;
  int         sel = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         pr_cnt = 0;
  int         er_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  tx_serial_cfg_if #(.DATA_BITS(8)) bus0 ();
  tx_serial_cfg_if #(.DATA_BITS(7)) bus1 ();
  tx_serial_cfg_if #(.DATA_BITS(8)) bus2 ();
  tx_serial_cfg_if #(.DATA_BITS(5)) bus3 ();

  assign bus0.partida = partida && (sel == 0);
  assign bus1.partida = partida && (sel == 1);
  assign bus2.partida = partida && (sel == 2);
  assign bus3.partida = partida && (sel == 3);
  assign bus0.dados = dados[7:0];
  assign bus1.dados = dados[6:0];
  assign bus2.dados = dados[7:0];
  assign bus3.dados = dados[4:0];

  tx_serial_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  tx_serial_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(3)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  tx_serial_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  tx_serial_cfg #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(1)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  logic       o_line, o_oc, o_pr, o_er;
  logic [3:0] o_db;
  always_comb begin
    case (sel)
      1:       {o_line, o_oc, o_pr, o_er, o_db} = {bus1.saida_serial, bus1.ocupado, bus1.pronto, bus1.erro_overrun, bus1.db_estado};
      2:       {o_line, o_oc, o_pr, o_er, o_db} = {bus2.saida_serial, bus2.ocupado, bus2.pronto, bus2.erro_overrun, bus2.db_estado};
      3:       {o_line, o_oc, o_pr, o_er, o_db} = {bus3.saida_serial, bus3.ocupado, bus3.pronto, bus3.erro_overrun, bus3.db_estado};
      default: {o_line, o_oc, o_pr, o_er, o_db} = {bus0.saida_serial, bus0.ocupado, bus0.pronto, bus0.erro_overrun, bus0.db_estado};
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a frame whose LOAD cycle is m_load sends bit i during
  // cycles m_load+1+i*C .. m_load+(i+1)*C and finishes at m_load+1+N*C.
  int         m_db = 8, m_par = 0, m_sb = 1, m_c = 4, m_n = 10;
  int         mt = 0, m_load = 0;
  bit         m_act = 0, m_full = 0, m_err = 0;
  logic [8:0] m_buf = '0, m_word = '0;

  function automatic logic fbit(input logic [8:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= m_db) return w[i-1];
    if (m_par != 0 && i == m_db + 1) return (m_par == 1) ? ~(^w) : ^w;
    return 1'b1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mt = 0; m_act = 0; m_full = 0; m_err = 0;
    end else begin
      bit in_load, done_now, cap, nfull;
      in_load  = m_act && (mt == m_load);
      done_now = m_act && (mt == m_load + 1 + m_n * m_c);
      cap      = partida && (!m_full || in_load);
      m_err    = partida && m_full && !in_load;
      if (in_load) m_word = m_buf;
      nfull = cap ? 1'b1 : (in_load ? 1'b0 : m_full);
      if (cap) m_buf = dados & 9'((1 << m_db) - 1);
      if (done_now) begin
        if (m_full) m_load = mt + 1;
        else        m_act = 0;
      end else if (!m_act && m_full) begin
        m_act = 1; m_load = mt + 1;
      end
      m_full = nfull;
      mt++;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      bit ld, snd, dn;
      int e_db;
      ld   = m_act && (mt == m_load);
      snd  = m_act && (mt > m_load) && (mt <= m_load + m_n * m_c);
      dn   = m_act && (mt == m_load + 1 + m_n * m_c);
      e_db = ld ? 1 : snd ? 3 : dn ? 15 : 0;
      chk("line", o_line, snd ? fbit(m_word, (mt - m_load - 1) / m_c) : 1'b1);
      chk("ocupado", o_oc, (m_act || m_full) ? 1 : 0);
      chk("pronto", o_pr, dn ? 1 : 0);
      chk("erro_overrun", o_er, m_err ? 1 : 0);
      chk("db_estado", o_db, e_db);
      if (o_pr) pr_cnt++;
      if (o_er) er_cnt++;
    end
  end

  task automatic select_dut(input int s, input int db, input int par, input int sb, input int c);
    @(negedge clock);
    reset = 1'b1; sel = s;
    m_db = db; m_par = par; m_sb = sb; m_c = c;
    m_n = 1 + db + ((par != 0) ? 1 : 0) + sb;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_line", o_line, 1);
    chk("rst_ocupado", o_oc, 0);
    chk("rst_db", o_db, 0);
    chk("rst_pronto", o_pr, 0);
    chk("rst_erro", o_er, 0);
  endtask

  task automatic send(input logic [8:0] w, output int k);
    @(negedge clock);
    partida = 1'b1; dados = w; k = cyc;
    @(negedge clock);
    partida = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 2000) begin
      @(negedge clock);
      g++;
    end
    if (cyc < target) chk("wait_timeout", cyc, target);
  endtask

  task automatic sample_bits(input int s, input int n, input int c, output logic [11:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      wait_cyc(s + i * c);
      bits[i] = o_line;
    end
  endtask

  task automatic wait_pronto(output int at);
    int g = 0;
    while (!o_pr && g < 2000) begin
      @(negedge clock);
      g++;
    end
    if (!o_pr) chk("pronto_timeout", 0, 1);
    at = cyc;
  endtask

  initial begin
    int k, k2, k3, p, p2, g, s2, pr0, er0;
    logic [11:0] b, b2;

    // 8N1, 4 clocks per bit
    select_dut(0, 8, 0, 1, 4);
    send(9'h055, k);
    sample_bits(k + 3, 10, 4, b);
    chk("8N1_bits", b[9:0], 10'h2AA);
    wait_pronto(p);
    chk("8N1_pronto_ofs", p - k, 43);
    @(negedge clock);
    chk("8N1_idle_after", o_oc, 0);

    // 7O1, 3 clocks per bit
    select_dut(1, 7, 1, 1, 3);
    send(9'h041, k);
    sample_bits(k + 3, 10, 3, b);
    chk("7O1_bits", b[9:0], 10'h382);
    wait_pronto(p);
    chk("7O1_pronto_ofs", p - k, 33);

    // 8E2 with a second word queued mid-frame
    select_dut(2, 8, 2, 2, 2);
    er0 = er_cnt;
    send(9'h0A5, k);
    fork
      sample_bits(k + 3, 12, 2, b);
      begin
        repeat (6) @(negedge clock);
        send(9'h03C, k2);
      end
    join
    chk("8E2_bits1", b, 12'hD4A);
    wait_pronto(p);
    chk("8E2_pronto_ofs", p - k, 27);
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (o_line && g < 10);
    chk("8E2_gap", g, 2);
    s2 = cyc;
    sample_bits(s2, 12, 2, b2);
    chk("8E2_bits2", b2, 12'hC78);
    wait_pronto(p2);
    chk("8E2_pronto2_ofs", p2 - s2, 24);
    chk("8E2_no_overrun", er_cnt - er0, 0);

    // overrun: one word in flight, one buffered, one dropped
    select_dut(0, 8, 0, 1, 4);
    er0 = er_cnt; pr0 = pr_cnt;
    send(9'h011, k);
    repeat (8) @(negedge clock);
    send(9'h022, k2);
    repeat (4) @(negedge clock);
    send(9'h033, k3);
    wait_pronto(p);
    sample_bits(p + 2, 10, 4, b);
    chk("ovr_bits2", b[9:0], 10'h244);
    wait_pronto(p2);
    chk("ovr_frame_gap", p2 - p, 42);
    repeat (100) @(negedge clock);
    chk("ovr_frames", pr_cnt - pr0, 2);
    chk("ovr_pulses", er_cnt - er0, 1);
    chk("ovr_idle", o_oc, 0);

    // reset during data bit 3 with a word waiting in the buffer
    select_dut(0, 8, 0, 1, 4);
    pr0 = pr_cnt;
    send(9'h000, k);
    repeat (8) @(negedge clock);
    send(9'h077, k2);
    wait_cyc(k + 20);
    chk("rstmid_line_before", o_line, 0);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_line", o_line, 1);
    chk("rstmid_ocupado", o_oc, 0);
    chk("rstmid_db", o_db, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (80) @(negedge clock);
    chk("rstmid_no_pronto", pr_cnt - pr0, 0);
    chk("rstmid_idle", o_oc, 0);

    // 5N1, one clock per bit
    select_dut(3, 5, 0, 1, 1);
    send(9'h01F, k);
    sample_bits(k + 3, 7, 1, b);
    chk("5N1_bits", b[6:0], 7'h7E);
    wait_pronto(p);
    chk("5N1_pronto_ofs", p - k, 10);
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
